multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execution unit that answers the controller's ALU start/done handshake.
- Accepts one operation per `start` pulse on two signed 16-bit operands.
- ADD/SUB complete in one cycle.
- MUL uses an iterative shift-add sequence; DIV uses iterative restoring division.
- Produces a registered `result` and a level `done`; sits between the register-file/immediate operand mux and the controller's writeback path.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request pulse; operands and op are sampled on the edge where start=1.
- op  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx treated as ADD (address generation).
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- result  output  WIDTH  signed registered result; stable while done=1.
- done  output  1  completion level; held until the next accepted start.
- busy  output  1  high while a MUL/DIV is iterating.

Behaviour:
- Reset values: result=0, done=0, busy=0, state=IDLE, counter=0, all internal datapath registers=0. Reset mid-operation aborts the operation; no done is produced afterwards.
- States: IDLE, MUL, DIV, DIV_FIX.
- IDLE, start=1, op ADD/SUB/1xx:
  - result <= a+b or a-b, modulo 2**WIDTH (no saturation).
  - done <= 1 on that same edge; stay in IDLE.
  - Latency: result valid the cycle after start.
- IDLE, start=1, op MUL:
  - On the start edge, load multiplicand=a, multiplier=b, acc=0, count=0, done<=0, busy<=1; go to MUL.
  - In MUL, each edge: if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1; count++.
  - On the 16th iteration edge: result<=low WIDTH bits of the product (two's-complement low half is sign-correct), done<=1, busy<=0, go to IDLE.
  - done rises 16 cycles after the start edge.
- IDLE, start=1, op DIV:
  - On the start edge, load |a|, |b|, quotient sign = a[15]^b[15], remainder=0, done<=0, busy<=1; go to DIV.
  - 16 restoring iterations, MSB first, one per edge.
  - Then DIV_FIX (one edge): negate the quotient if the sign bit is set; result<=quotient, done<=1, busy<=0, go to IDLE.
  - done rises 17 cycles after the start edge.
  - Quotient truncates toward zero: -7/2 = -3.
- DIV boundary cases:
  - b=0: full latency still applies; result=16'hFFFF.
  - -32768 / -1: result=-32768 (wraps). |-32768| is handled as unsigned 32768.
- Every accepted start clears done on its sampling edge; ADD/SUB set it again on that same edge.
- start while busy=1 is ignored: operands are not resampled and no state change occurs.
- start held high in IDLE for several cycles: each edge is a new request; the last one wins.
- result keeps the previous value while MUL/DIV iterate and only updates at completion.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: adds outputs `zero` (result==0), `neg` (result[15]) and `div0` (last DIV had b==0). All three are registered together with result, reset to 0, and cleared by any accepted start except where recomputed.
- Undefined: these ports and registers are absent; core behaviour is identical.

Decomposition:
- Shared package alu_pkg: op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV), state localparams, WIDTH default, DIV0_RESULT constant 16'hFFFF.
- Natural sub-module: seq_divider. It holds the restoring-divide datapath on unsigned magnitudes with its own start/done; the top handles sign conversion, MUL and the handshake.

Test Plan:
- Reset mid-MUL:
  - Start ADD a=5, b=-9 -> next cycle result=-4, done=1.
  - Start SUB a=-32768, b=1 -> result=32767 (wrap).
  - Start MUL a=300, b=-7, then assert rst after 8 cycles -> result=0, done=0, busy=0, and no done afterwards.
- MUL a=-123, b=45 -> done low for cycles 1-15, high at cycle 16; result=-5535; done stays high until the next start.
- DIV a=-7, b=2 -> done at cycle 17, result=-3.
- DIV a=-32768, b=-1 -> result=-32768.
- DIV a=100, b=0 -> result=16'hFFFF (and div0=1 with ALU_FLAGS_EN).
- Start DIV a=1000, b=10; pulse start with op ADD at cycle 5 -> the ADD is ignored; final result=100 at cycle 17.
- Back-to-back: ADD done, then MUL start on the next cycle -> done drops on the MUL start edge and re-asserts 16 cycles later with the product.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op encodings, FSM states, defaults.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Result reported for any divide by zero, regardless of operand signs.
  localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV     = 2'd2,
    S_DIV_FIX = 2'd3
  } alu_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// done_o is high during the cycle whose closing edge performs the last
// iteration, so quotient_o is final from the following cycle onward.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             done_o
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   rem_sh, diff;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  // Quotient bits are shifted into the dividend register as it empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH-1)) busy_q <= 1'b0;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = busy_q && (cnt_q == CNT_W'(WIDTH-1));

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/SUB, 16-step shift-add MUL, restoring DIV
// (via seq_divider) plus a sign-fix cycle. done is a level held until the
// next accepted start. Optional ALU_FLAGS_EN adds zero/neg/div0 outputs.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             div0
`endif
);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic             qsign_q, qsign_d, divz_q, divz_d;
  logic             div_start, div_done;
  logic [WIDTH-1:0] a_mag, b_mag, quo;

  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  seq_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quotient_o (quo),
    .done_o     (div_done)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      qsign_q  <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      qsign_q  <= qsign_d;
      divz_q   <= divz_d;
    end
  end

  // Next-state and datapath updates; starts are only accepted in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    result_d  = result_q;
    done_d    = done_q;
    busy_d    = busy_q;
    qsign_d   = qsign_q;
    divz_d    = divz_q;
    div_start = 1'b0;
    acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          case (op)
            OP_SUB: begin
              result_d = a - b;
              done_d   = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = a;
              mplier_d = b;
              acc_d    = '0;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_MUL;
            end
            OP_DIV: begin
              div_start = 1'b1;
              qsign_d   = a[WIDTH-1] ^ b[WIDTH-1];
              divz_d    = (b == '0);
              busy_d    = 1'b1;
              state_d   = S_DIV;
            end
            default: begin  // ADD and 1xx (address generation)
              result_d = a + b;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Low half of the two's-complement product is already sign-correct.
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          result_d = acc_nxt;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_DIV: begin
        if (div_done) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        if (divz_q)       result_d = WIDTH'(DIV0_RESULT);
        else if (qsign_q) result_d = ~quo + 1'b1;
        else              result_d = quo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

`ifdef ALU_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, div0_q, div0_d;

  // Flags follow result: cleared on accepted start, set when result is written.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    div0_d = div0_q;
    if (state_q == S_IDLE && start) begin
      zero_d = done_d && (result_d == '0);
      neg_d  = done_d && result_d[WIDTH-1];
      div0_d = 1'b0;
    end else if (done_d && !done_q) begin
      zero_d = (result_d == '0);
      neg_d  = result_d[WIDTH-1];
      div0_d = (state_q == S_DIV_FIX) && divz_q;
    end
  end

  // Flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      div0_q <= div0_d;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized + directed bench for multicycle_alu against an arithmetic model.
module tb_multicycle_alu;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst, start;
  logic [2:0]          op;
  logic signed [W-1:0] a, b;
  logic [W-1:0]        result;
  logic                done, busy;
`ifdef ALU_FLAGS_EN
  logic                zero, neg, div0;
`endif

  multicycle_alu #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .done(done), .busy(busy)
`ifdef ALU_FLAGS_EN
    , .zero(zero), .neg(neg), .div0(div0)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [W-1:0] prev_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference for the operation's final result.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic signed [W-1:0] x,
                                         input logic signed [W-1:0] y);
    int xi, yi;
    longint p;
    xi = x;
    yi = y;
    case (o)
      3'b001: return W'(xi - yi);
      3'b010: begin p = longint'(xi) * longint'(yi); return p[W-1:0]; end
      3'b011: begin if (yi == 0) return '1; return W'(xi / yi); end
      default: return W'(xi + yi);
    endcase
  endfunction

  // Edge index (start edge = 0) at which done rises.
  function automatic int lat_of(input logic [2:0] o);
    if (o == 3'b010) return 16;
    if (o == 3'b011) return 17;
    return 0;
  endfunction

  // Issue one op at the current negedge; optionally poke a stray ADD start
  // after 'poke' edges. Checks latency, busy, result hold and final value.
  task automatic run_op(input string nm, input logic [2:0] o, input logic signed [W-1:0] x,
                        input logic signed [W-1:0] y, input int poke);
    logic [W-1:0] exp;
    int lat, bad;
    exp = model(o, x, y);
    lat = lat_of(o);
    bad = 0;
    start = 1'b1; op = o; a = x; b = y;
    for (int j = 0; j <= lat; j++) begin
      @(negedge clk);
      if (j == 0) begin start = 1'b0; a = W'($urandom); b = W'($urandom); end
      if (j == poke) begin start = 1'b1; op = 3'b000; a = 16'sd1; b = 16'sd1; end
      else if (j == poke + 1) start = 1'b0;
      if (j < lat) begin
        if (done)               bad++;
        if (!busy)              bad++;
        if (result !== prev_res) bad++;
      end
    end
    if (lat > 0) chk({nm, "_iter"}, 32'(bad), 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_res"}, {16'd0, result}, {16'd0, exp});
`ifdef ALU_FLAGS_EN
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, exp == '0});
    chk({nm, "_neg"},  {31'd0, neg},  {31'd0, exp[W-1]});
    chk({nm, "_div0"}, {31'd0, div0}, {31'd0, (o == 3'b011) && (y == '0)});
`endif
    prev_res = exp;
  endtask

  initial begin
    int cnt;
    logic [2:0] ro;
    logic signed [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; prev_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_res",  {16'd0, result}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add", 3'b000, 16'sd5, -16'sd9, -9);
    run_op("sub_wrap", 3'b001, -16'sd32768, 16'sd1, -9);

    // Abort a MUL with reset after 8 edges; nothing may complete afterwards.
    start = 1'b1; op = 3'b010; a = 16'sd300; b = -16'sd7;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_res",  {16'd0, result}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (done || busy) cnt++; end
    chk("mrst_quiet", 32'(cnt), 32'd0);
    prev_res = '0;

    run_op("mul", 3'b010, -16'sd123, 16'sd45, -9);
    cnt = 0;
    repeat (3) begin @(negedge clk); if (!done || result !== prev_res) cnt++; end
    chk("mul_hold", 32'(cnt), 32'd0);

    run_op("div_neg", 3'b011, -16'sd7, 16'sd2, -9);
    run_op("div_ovf", 3'b011, -16'sd32768, -16'sd1, -9);
    run_op("div0", 3'b011, 16'sd100, 16'sd0, -9);
    run_op("div_ign", 3'b011, 16'sd1000, 16'sd10, 5);
    run_op("b2b_add", 3'b000, 16'sd7, 16'sd8, -9);
    run_op("b2b_mul", 3'b010, 16'sd311, -16'sd201, -9);
    run_op("agen", 3'b110, 16'sd1200, -16'sd34, -9);

    for (int i = 0; i < 80; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = W'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 16'sd0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) ry = W'($urandom_range(0, 40)) - 16'sd20;
      run_op("rnd", ro, rx, ry, -9);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
